// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit framer.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a data word; even or odd selected by par_typ_i.
module parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              par_typ_i,
  output logic              par_o
);

  logic red;

  assign red = ^data_i;

  always_comb begin
    par_o = red;
    unique case (par_typ_i)
      PAR_EVEN: par_o = red;
      PAR_ODD:  par_o = ~red;
      default:  par_o = red;
    endcase
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stops.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] p_data,
  input  logic              data_valid,
  input  logic              par_en,
  input  logic              par_typ,
  output logic              tx_out,
  output logic              busy
);

  localparam int unsigned     CntW     = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastBit  = CntW'(DATA_W - 1);
  localparam logic            LastStop = (STOP_BITS == 2);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_frame: DATA_W must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  tx_state_e       state_q;
  logic [DATA_W-1:0] data_q;
  logic            par_en_q;
  logic            par_typ_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [CntW-1:0] bit_nxt;
  logic            stop_cnt_q;
  logic            tx_q;
  logic            busy_q;
  logic            par_bit;

  assign bit_nxt = bit_cnt_q + CntW'(1);

  parity_calc #(
    .DATA_W (DATA_W)
  ) u_parity_calc (
    .data_i    (data_q),
    .par_typ_i (par_typ_q),
    .par_o     (par_bit)
  );

  // tx_q is loaded with the value of the state being entered, so the line changes
  // exactly on the tick edge that starts each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (data_valid) begin
            data_q    <= p_data;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            busy_q    <= 1'b1;
            state_q   <= StArmed;
          end
        end
        StArmed: begin
          if (baud_tick) begin
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_tick) begin
            bit_cnt_q <= '0;
            tx_q      <= data_q[0];
            state_q   <= StData;
          end
        end
        StData: begin
          if (baud_tick) begin
            if (bit_cnt_q == LastBit) begin
              stop_cnt_q <= 1'b0;
              if (par_en_q) begin
                tx_q    <= par_bit;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              bit_cnt_q <= bit_nxt;
              tx_q      <= data_q[bit_nxt];
            end
          end
        end
        StParity: begin
          if (baud_tick) begin
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            state_q    <= StStop;
          end
        end
        StStop: begin
          if (baud_tick) begin
            if (stop_cnt_q == LastStop) begin
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
              state_q <= StIdle;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule
